// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max pooling over a column-pair stream from the conv stage.
// Pooled samples are buffered in a small FIFO with valid/ready handshaking toward the next stage.
module max_pool_2x2 #(
   parameter int DW    = 18,
   parameter int IN_W  = 26,
   parameter int IN_H  = 26,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 strt,
   input  logic                 vld_in,
   output logic                 rdy_in,
   input  logic signed [DW-1:0] din_0,
   input  logic signed [DW-1:0] din_1,
   output logic                 vld_out,
   input  logic                 rdy_out,
   output logic signed [DW-1:0] dout,
   output logic                 bsy,
   output logic                 done
);

   localparam int CW  = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int RPW = (IN_H / 2 > 1) ? $clog2(IN_H / 2) : 1;
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CW-1:0]  COL_LAST = CW'(IN_W - 1);
   localparam logic [RPW-1:0] RP_LAST  = RPW'(IN_H / 2 - 1);
   localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   state_t                r_state;
   state_t                w_next;
   logic [CW-1:0]         r_col;
   logic [RPW-1:0]        r_rp;
   logic signed [DW-1:0]  r_part;
   logic signed [DW-1:0]  r_mem [DEPTH];
   logic [AW-1:0]         r_wr;
   logic [AW-1:0]         r_rd;
   logic [AW:0]           r_cnt;

   logic                  w_rdy;
   logic                  w_acc;
   logic                  w_last;
   logic                  w_push;
   logic                  w_pop;
   logic signed [DW-1:0]  w_m;
   logic signed [DW-1:0]  w_pool;

   // Full is taken from the registered count only, so a same-cycle pop never re-opens rdy_in.
   assign w_rdy   = (r_state == S_RUN) && (r_cnt != CNT_FULL);
   assign w_acc   = vld_in && w_rdy;
   assign w_last  = w_acc && (r_col == COL_LAST) && (r_rp == RP_LAST);
   assign w_m     = smax(din_0, din_1);
   assign w_pool  = smax(r_part, w_m);
   assign w_push  = w_acc && r_col[0];
   assign w_pop   = vld_out && rdy_out;

   assign rdy_in  = w_rdy;
   assign vld_out = (r_cnt != '0);
   assign dout    = vld_out ? r_mem[r_rd] : '0;
   assign bsy     = (r_state != S_IDLE);
   assign done    = (r_state == S_DRAIN) && (r_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (strt) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DRAIN;
         S_DRAIN: if (r_cnt == '0) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col  <= '0;
         r_rp   <= '0;
         r_part <= '0;
      end else begin
         if ((r_state == S_IDLE) && strt) begin
            r_col <= '0;
            r_rp  <= '0;
         end else if (w_acc) begin
            if (r_col == COL_LAST) begin
               r_col <= '0;
               r_rp  <= r_rp + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         // Even columns open a window; odd columns close it against this value.
         if (w_acc && !r_col[0]) r_part <= w_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= w_pool;
   end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Randomized self-checking bench for max_pool_2x2: frames are pooled by a
// plain-arithmetic window model and every FIFO pop is compared in order.
module tb_max_pool_2x2;

   localparam int DW    = 18;
   localparam int IN_W  = 26;
   localparam int IN_H  = 26;
   localparam int DEPTH = 4;
   localparam int NPAIR = IN_W * (IN_H / 2);
   localparam int LIMIT = 20000;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 strt = 1'b0;
   logic                 vld_in = 1'b0;
   logic                 rdy_in;
   logic signed [DW-1:0] din_0 = '0;
   logic signed [DW-1:0] din_1 = '0;
   logic                 vld_out;
   logic                 rdy_out = 1'b0;
   logic signed [DW-1:0] dout;
   logic                 bsy;
   logic                 done;

   int n_cmp = 0;
   int n_err = 0;
   int frame [IN_H][IN_W];
   int exp_q [$];

   always #5 clk = ~clk;

   max_pool_2x2 #(.DW(DW), .IN_W(IN_W), .IN_H(IN_H), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .strt    (strt),
      .vld_in  (vld_in),
      .rdy_in  (rdy_in),
      .din_0   (din_0),
      .din_1   (din_1),
      .vld_out (vld_out),
      .rdy_out (rdy_out),
      .dout    (dout),
      .bsy     (bsy),
      .done    (done)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int rnd_sample();
      logic signed [DW-1:0] t;
      case ($urandom % 6)
         0:       t = {1'b0, {(DW-1){1'b1}}};
         1:       t = {1'b1, {(DW-1){1'b0}}};
         2:       t = DW'($urandom_range(0, 6)) - DW'(3);
         default: t = DW'($urandom);
      endcase
      return int'(t);
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   task automatic gen_frame(input bit ramp);
      for (int r = 0; r < IN_H; r++)
         for (int c = 0; c < IN_W; c++)
            frame[r][c] = ramp ? (r * IN_W + c) : rnd_sample();
      exp_q.delete();
      for (int rp = 0; rp < IN_H / 2; rp++)
         for (int cp = 0; cp < IN_W / 2; cp++)
            exp_q.push_back(max4(frame[2*rp][2*cp], frame[2*rp+1][2*cp],
                                 frame[2*rp][2*cp+1], frame[2*rp+1][2*cp+1]));
   endtask

   task automatic do_reset(input bit check);
      @(negedge clk);
      rst_n = 1'b0; strt = 1'b0; vld_in = 1'b0; rdy_out = 1'b0;
      #1;
      if (check) begin
         chk("rst_rdy_in", rdy_in, 0);
         chk("rst_vld_out", vld_out, 0);
         chk("rst_dout", $signed(dout), 0);
         chk("rst_bsy", bsy, 0);
         chk("rst_done", done, 0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic start();
      @(negedge clk);
      strt = 1'b1;
      @(negedge clk);
      strt = 1'b0;
   endtask

   task automatic put_pair(input int a, input int b);
      int t;
      t = 0;
      @(negedge clk);
      vld_in = 1'b1; din_0 = DW'(a); din_1 = DW'(b);
      #1;
      while (!rdy_in && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (t >= 50) chk("put_timeout", 1, 0);
      @(posedge clk);
      #1;
      vld_in = 1'b0;
   endtask

   task automatic run_frame(input int vld_pct, input int rdy_pct, input int strt_pct, input int stop_after);
      int  k;
      int  cyc;
      bit  fin;
      k = 0; cyc = 0; fin = 1'b0;
      while (!fin && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
         rdy_out = ($urandom % 100) < rdy_pct;
         strt    = (k > 0) && (k < NPAIR) && (($urandom % 100) < strt_pct);
         if (k < NPAIR && ($urandom % 100) < vld_pct) begin
            vld_in = 1'b1;
            din_0  = DW'(frame[2*(k/IN_W)][k%IN_W]);
            din_1  = DW'(frame[2*(k/IN_W)+1][k%IN_W]);
         end else begin
            vld_in = 1'b0;
            din_0  = DW'($urandom);
            din_1  = DW'($urandom);
         end
         #1;
         if (vld_out && rdy_out) begin
            if (exp_q.size() == 0) chk("extra_output", 1, 0);
            else chk("pool_out", $signed(dout), exp_q.pop_front());
         end
         if (done) begin
            chk("done_q_empty", exp_q.size(), 0);
            fin = 1'b1;
         end
         if (vld_in && rdy_in) k++;
         if (stop_after > 0 && k == stop_after) fin = 1'b1;
      end
      @(posedge clk);
      #1;
      strt = 1'b0; vld_in = 1'b0;
      if (stop_after == 0) begin
         chk("frame_finished", fin, 1);
         chk("pairs_accepted", k, NPAIR);
         chk("bsy_after_done", bsy, 0);
         chk("done_single_pulse", done, 0);
      end
   endtask

   initial begin
      int pa [12];
      int pb [12];
      int acc;

      do_reset(1'b1);

      // Single windows, including an all-negative one that needs signed compare.
      start();
      rdy_out = 1'b1;
      chk("bsy_run", bsy, 1);
      put_pair(3, -7);
      chk("w1_no_early_out", vld_out, 0);
      put_pair(5, 2);
      chk("w1_vld", vld_out, 1);
      chk("w1_val", $signed(dout), 5);
      put_pair(-9, -4);
      put_pair(-1, -200);
      chk("w2_vld", vld_out, 1);
      chk("w2_val", $signed(dout), -1);

      // Backpressure: FIFO fills to DEPTH, then drains in order.
      do_reset(1'b0);
      start();
      for (int i = 0; i < 12; i++) begin
         pa[i] = rnd_sample();
         pb[i] = rnd_sample();
      end
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rdy_out = 1'b0;
         vld_in  = 1'b1;
         din_0   = DW'(pa[acc < 12 ? acc : 11]);
         din_1   = DW'(pb[acc < 12 ? acc : 11]);
         #1;
         if (rdy_in) acc++;
      end
      chk("bp_accepts", acc, 2 * DEPTH);
      chk("bp_rdy_in_low", rdy_in, 0);
      chk("bp_vld_out", vld_out, 1);
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         vld_in = 1'b0; rdy_out = 1'b1;
         #1;
         chk("bp_drain_vld", vld_out, 1);
         chk("bp_drain_val", $signed(dout), max4(pa[2*i], pb[2*i], pa[2*i+1], pb[2*i+1]));
      end
      @(negedge clk);
      #1;
      chk("bp_empty", vld_out, 0);

      // vld_in asserted while idle must not be accepted.
      do_reset(1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vld_in = 1'b1; rdy_out = 1'b1;
         din_0 = DW'($urandom); din_1 = DW'($urandom);
         #1;
         chk("idle_rdy_in", rdy_in, 0);
         chk("idle_vld_out", vld_out, 0);
      end
      vld_in = 1'b0;

      // Ramp frame: each pooled value is the bottom-right sample of its window.
      gen_frame(1'b1);
      start();
      run_frame(100, 100, 0, 0);

      // Random frames with stalls on both sides and stray strt pulses.
      gen_frame(1'b0);
      start();
      run_frame(70, 50, 5, 0);
      gen_frame(1'b0);
      start();
      run_frame(90, 20, 5, 0);

      // Abort mid-frame, then a clean frame must still be correct.
      gen_frame(1'b0);
      start();
      run_frame(100, 100, 0, 40);
      do_reset(1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("post_rst_done", done, 0);
         chk("post_rst_vld_out", vld_out, 0);
      end
      gen_frame(1'b0);
      start();
      run_frame(80, 60, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
- Downstream neighbour of the first convolution stage: 2x2, stride-2 signed max pooling over the conv feature map.
- The conv stage presents two vertically adjacent output rows in parallel, one column per transfer.
- Pooled results go into a small output FIFO with a valid/ready interface, so the next conv stage can stall without dropping data.
- Reports busy while active and pulses done when a full frame has been pooled and drained.

Parameters:
- DW, 18, data width of input and output samples (signed two's complement)
- IN_W, 26, input feature-map columns per row
- IN_H, 26, input feature-map rows
- DEPTH, 4, output FIFO depth in entries (power of 2)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- strt  input  1  single-cycle pulse; starts a frame when idle
- vld_in  input  1  din_0/din_1 hold a valid column pair
- rdy_in  output  1  block accepts a column pair this cycle
- din_0  input  DW  sample at (row 2r, column c)
- din_1  input  DW  sample at (row 2r+1, column c)
- vld_out  output  1  dout holds a valid pooled sample (FIFO not empty)
- rdy_out  input  1  downstream consumes dout this cycle
- dout  output  DW  FIFO head, pooled sample
- bsy  output  1  high whenever state is not IDLE
- done  output  1  single-cycle pulse at end of frame

Behaviour:
- Reset (async, rst_n low): state IDLE; column, row and FIFO pointers/count cleared; partial-max register 0; rdy_in=0, vld_out=0, dout=0, bsy=0, done=0. Reset mid-frame discards all data; no done pulse.
- States:
  - IDLE: rdy_in=0, vld_in ignored. strt -> RUN; column counter col and row-pair counter rp cleared.
  - RUN: rdy_in = !full, where full means count==DEPTH (registered, no same-cycle pop look-ahead). An accept is vld_in && rdy_in.
  - DRAIN: rdy_in=0; leaves for IDLE when the FIFO is empty, pulsing done=1 for exactly that cycle.
- strt is ignored outside IDLE.
- Per accept in RUN:
  - m = signed max(din_0, din_1).
  - Even col: partial register <= m.
  - Odd col: push signed max(partial, m) into the FIFO.
  - Ties give the equal value.
  - col increments, wrapping to 0 after IN_W-1, at which point rp increments.
- Odd IN_W: the final even column of each row pair is accepted but produces no output.
- After the accept with col==IN_W-1 and rp==IN_H/2-1, go to DRAIN. Odd IN_H: the last input row is never requested.
- Output rate: (IN_W/2)*(IN_H/2) pooled samples per frame (169 at defaults).
- FIFO:
  - vld_out = count!=0; dout = head entry.
  - Pop on vld_out && rdy_out.
  - Push and pop in the same cycle is legal at any count; count is unchanged.
  - Push while full cannot occur, because rdy_in is low.
  - Pointers wrap modulo DEPTH.
- Latency: the pooled sample appears on dout/vld_out the cycle after its odd-column accept, if the FIFO was empty.
- No arithmetic widening: outputs are selected input samples, so width stays DW.

Test Plan:
1. Window check: strt; pairs (3,-7) then (5,2) with rdy_out=1 -> one output 5, vld_out high the cycle after the second accept.
2. All-negative window: pairs (-9,-4) then (-1,-200) -> output -1, which also checks that the comparison is signed, not unsigned.
3. Backpressure: rdy_out=0 with vld_in held high. Exactly 4 pooled values are buffered, then rdy_in drops after the 4th push. Raising rdy_out then drains them in order with no loss or duplication.
4. Full frame at defaults: input ramp value = row*26+col. Expect 169 outputs, each equal to the bottom-right sample of its window. done pulses once after the last pop, then bsy falls.
5. Control robustness:
   - strt pulsed during RUN -> ignored, counts unaffected.
   - vld_in high in IDLE -> no accepts, no outputs.
6. Reset mid-frame: assert rst_n low after 40 accepts -> all outputs 0, FIFO empty, no done. A new strt then produces a correct full frame.
